// File: rtl/temp_bcd_converter.sv
// Signed 12-bit sensor temperature to sign + BCD (hundreds/tens/ones/tenths) via iterative double-dabble.
// Optional tenths digit: define TEMP_FRAC_EN to enable; otherwise bcd_tenth is tied to 0.
module temp_bcd_converter #(
    parameter int INT_BITS    = 8,
    parameter int SHIFT_CNT_W = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] MSB,
    input  logic [7:0] LSB,
    input  logic       valid,
    output logic       busy,
    output logic       done,
    output logic       sign,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic [3:0] bcd_tenth
);

    localparam int BCD_W = 12;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ABS   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [SHIFT_CNT_W-1:0] LAST_SHIFT = SHIFT_CNT_W'(INT_BITS - 1);

    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    logic [1:0]             state_q,  state_d;
    logic [11:0]            raw_q,    raw_d;
    logic                   neg_q,    neg_d;
    logic                   nz_q,     nz_d;
    logic [INT_BITS-1:0]    int_sr_q, int_sr_d;
    logic [BCD_W-1:0]       bcd_q,    bcd_d;
    logic [SHIFT_CNT_W-1:0] cnt_q,    cnt_d;
    logic                   done_q,   done_d;
    logic                   sign_q,   sign_d;
    logic [3:0]             hund_q,   hund_d;
    logic [3:0]             tens_q,   tens_d;
    logic [3:0]             ones_q,   ones_d;
`ifdef TEMP_FRAC_EN
    logic [3:0]             frac_q,   frac_d;
    logic [3:0]             tenth_q,  tenth_d;
    logic [3:0]             frac_mag;
`endif

    logic [INT_BITS-1:0] int_mag;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_shift;
    logic [INT_BITS-1:0] sr_shift;

    // The low LSB nibble carries no temperature data.
    logic unused_lsb;
    assign unused_lsb = ^LSB[3:0];

    // Integer magnitude straight from the raw word: for negatives, ~x+1 only carries
    // into the integer part when the fractional nibble is zero.
    assign int_mag = raw_q[11]
                   ? (~raw_q[11:4] + {{(INT_BITS-1){1'b0}}, ~|raw_q[3:0]})
                   : raw_q[11:4];
`ifdef TEMP_FRAC_EN
    assign frac_mag = raw_q[11] ? (~raw_q[3:0] + 4'd1) : raw_q[3:0];
`endif

    assign bcd_adj   = {dd_adjust(bcd_q[11:8]), dd_adjust(bcd_q[7:4]), dd_adjust(bcd_q[3:0])};
    assign bcd_shift = {bcd_adj[BCD_W-2:0], int_sr_q[INT_BITS-1]};
    assign sr_shift  = {int_sr_q[INT_BITS-2:0], 1'b0};

    always_comb begin
        // NOTE: every _d gets a hold default first so no path through the case infers a latch.
        state_d  = state_q;
        raw_d    = raw_q;
        neg_d    = neg_q;
        nz_d     = nz_q;
        int_sr_d = int_sr_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        sign_d   = sign_q;
        hund_d   = hund_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
`ifdef TEMP_FRAC_EN
        frac_d   = frac_q;
        tenth_d  = tenth_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    raw_d   = {MSB, LSB[7:4]};
                    state_d = ST_ABS;
                end
            end
            ST_ABS: begin
                neg_d    = raw_q[11];
                int_sr_d = int_mag;
                bcd_d    = '0;
                cnt_d    = '0;
`ifdef TEMP_FRAC_EN
                frac_d   = frac_mag;
                nz_d     = (int_mag != '0) || (frac_mag != 4'd0);
`else
                nz_d     = (int_mag != '0);
`endif
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                bcd_d    = bcd_shift;
                int_sr_d = sr_shift;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_SHIFT) begin
                    // Results land on the same edge as the final shift, i.e. on DONE entry.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    sign_d  = neg_q & nz_q;
                    hund_d  = bcd_shift[11:8];
                    tens_d  = bcd_shift[7:4];
                    ones_d  = bcd_shift[3:0];
`ifdef TEMP_FRAC_EN
                    tenth_d = 4'(({4'd0, frac_q} * 8'd10) >> 4);
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            raw_q    <= '0;
            neg_q    <= 1'b0;
            nz_q     <= 1'b0;
            int_sr_q <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            sign_q   <= 1'b0;
            hund_q   <= '0;
            tens_q   <= '0;
            ones_q   <= '0;
`ifdef TEMP_FRAC_EN
            frac_q   <= '0;
            tenth_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            raw_q    <= raw_d;
            neg_q    <= neg_d;
            nz_q     <= nz_d;
            int_sr_q <= int_sr_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            sign_q   <= sign_d;
            hund_q   <= hund_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
`ifdef TEMP_FRAC_EN
            frac_q   <= frac_d;
            tenth_q  <= tenth_d;
`endif
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign sign     = sign_q;
    assign bcd_hund = hund_q;
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;
`ifdef TEMP_FRAC_EN
    assign bcd_tenth = tenth_q;
`else
    assign bcd_tenth = 4'd0;
`endif

endmodule
